gpio_port_v2: RTL and testbench

Parametrised general-purpose I/O port on the Avalon-MM slave bus, successor to the fixed 8-bit PIO used in the EDM systems. Provides WIDTH bidirectional pins with per-pin direction, atomic set/clear, per-pin rising/falling edge selection, per-pin edge or level interrupt mode, and optional input debouncing. Sits between the Nios interconnect and board-level pins such as buttons, LEDs and headers.

---
 rtl/gpio_port_pkg.sv | 18 +
 rtl/gpio_debounce.sv | 57 +++++
 rtl/gpio_port_v2.sv | 129 ++++++++++++
 tb/tb_gpio_port_v2.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_port_pkg.sv
// Shared register map and address type for the gpio_port_v2 block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package gpio_port_pkg;

    typedef logic [3:0] addr_t;

    localparam addr_t ADDR_DATA         = 4'd0;
    localparam addr_t ADDR_DATA_DIR     = 4'd1;
    localparam addr_t ADDR_IRQ_MASK     = 4'd2;
    localparam addr_t ADDR_EDGE_CAPTURE = 4'd3;
    localparam addr_t ADDR_OUTSET       = 4'd4;
    localparam addr_t ADDR_OUTCLEAR     = 4'd5;
    localparam addr_t ADDR_RISE_EN      = 4'd6;
    localparam addr_t ADDR_FALL_EN      = 4'd7;
    localparam addr_t ADDR_LEVEL_MODE   = 4'd8;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin input conditioner: SYNC_STAGES-flop synchroniser, then an optional stability filter (PIO_DEBOUNCE_EN).
// Latency: SYNC_STAGES-1 edges to filt_in, plus DEBOUNCE_CYCLES edges when PIO_DEBOUNCE_EN is defined.
// Backpressure: none; free-running sampler.
module gpio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic filt_in
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    // Shift the raw pad value through the metastability chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          filt_q;

    // Count consecutive cycles of disagreement; any agreement (a bounce back) restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            filt_q <= 1'b0;
        end else if (sync_out == filt_q) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            // The count reaching DEBOUNCE_CYCLES is the toggle point.
            filt_q <= sync_out;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign filt_in = filt_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign filt_in = sync_out;
`endif

endmodule

// File: rtl/gpio_port_v2.sv
// Avalon-MM GPIO port: per-pin direction, set/clear, edge/level interrupts; PIO_DEBOUNCE_EN adds input debouncing.
// Latency: reads 1 cycle, writes take effect at the sampling edge, irq registered.
// Backpressure: none; no wait states, every access completes in one cycle.
module gpio_port_v2
    import gpio_port_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_DIR       = '0,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  addr_t            address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    logic             wr_stb;
    logic [WIDTH-1:0] wdat;
    logic             unused_writedata;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] level_mode;

    logic [WIDTH-1:0] filt_in;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] w1c_vec;
    logic [WIDTH-1:0] irq_src;

    assign wr_stb           = chipselect & ~write_n;
    assign wdat             = writedata[WIDTH-1:0];
    assign unused_writedata = &{1'b0, writedata};

    // Per-pin tristate driver and input conditioner.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;

        gpio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (bidir_port[i]),
            .filt_in (filt_in[i])
        );
    end

    assign edge_vec = (rise_en & filt_in & ~prev_in) | (fall_en & ~filt_in & prev_in);
    assign w1c_vec  = (wr_stb && address == ADDR_EDGE_CAPTURE) ? wdat : '0;
    assign irq_src  = (level_mode & filt_in) | (~level_mode & edge_capture);

    // Software-visible control registers and the one-cycle input history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= RESET_OUT;
            data_dir   <= RESET_DIR;
            irq_mask   <= '0;
            rise_en    <= '1;
            fall_en    <= '0;
            level_mode <= '0;
            prev_in    <= '0;
        end else begin
            prev_in <= filt_in;
            if (wr_stb) begin
                case (address)
                    ADDR_DATA:       data_out   <= wdat;
                    ADDR_DATA_DIR:   data_dir   <= wdat;
                    ADDR_IRQ_MASK:   irq_mask   <= wdat;
                    ADDR_OUTSET:     data_out   <= data_out | wdat;
                    ADDR_OUTCLEAR:   data_out   <= data_out & ~wdat;
                    ADDR_RISE_EN:    rise_en    <= wdat;
                    ADDR_FALL_EN:    fall_en    <= wdat;
                    ADDR_LEVEL_MODE: level_mode <= wdat;
                    default: ;
                endcase
            end
        end
    end

    // Edge capture: a fresh edge overrides a simultaneous clear so no event is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~w1c_vec) | edge_vec;
        end
    end

    // Registered read mux, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA:         readdata <= 32'(filt_in);
                ADDR_DATA_DIR:     readdata <= 32'(data_dir);
                ADDR_IRQ_MASK:     readdata <= 32'(irq_mask);
                ADDR_EDGE_CAPTURE: readdata <= 32'(edge_capture);
                ADDR_RISE_EN:      readdata <= 32'(rise_en);
                ADDR_FALL_EN:      readdata <= 32'(fall_en);
                ADDR_LEVEL_MODE:   readdata <= 32'(level_mode);
                default:           readdata <= '0;
            endcase
        end
    end

    // Interrupt request registered from masked sources.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(irq_src & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpio_port_v2.sv
// Directed, table-driven bench for gpio_port_v2 with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpio_port_v2;

`ifdef PIO_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    // Pad change ahead of edge k reaches filt_in at edge k+LAT.
    localparam int LAT = 1 + DB;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] dat;
        int          dly;
    } op_t;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    wire  [7:0]  pins;

    logic [7:0]  tb_en;
    logic [7:0]  tb_val;

    int n_checks;
    int n_errors;

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_port_v2 #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .RESET_DIR       (8'h0F),
        .RESET_OUT       (8'h05)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .bidir_port (pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic run_table(input op_t tab[$], input string tag);
        logic [31:0] v;
        foreach (tab[i]) begin
            repeat (tab[i].dly) @(negedge clk);
            if (tab[i].wr) begin
                bus_wr(tab[i].addr, tab[i].dat);
            end else begin
                bus_rd(tab[i].addr, v);
                check($sformatf("%s[%0d] rd addr %0d", tag, i, tab[i].addr), v, tab[i].dat);
            end
        end
    endtask

    op_t tab1[$];
    op_t tab2[$];
    logic [31:0] v;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        tb_en      = 8'hF0;
        tb_val     = 8'hA0;

        // Reset state: low nibble driven from RESET_OUT, upper nibble released to the bench.
        repeat (3) @(negedge clk);
        check("reset readdata", readdata, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset pins_lo", 32'(pins[3:0]), 32'h5);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);

        // Post-reset register contents; captures reflect the 0->1 transitions on pins 0,2,5,7.
        tab1 = '{
            '{1'b0, 4'd0,  32'hA5,       0},
            '{1'b0, 4'd1,  32'h0F,       0},
            '{1'b0, 4'd2,  32'h00,       0},
            '{1'b0, 4'd3,  32'hA5,       0},
            '{1'b0, 4'd4,  32'h00,       0},
            '{1'b0, 4'd5,  32'h00,       0},
            '{1'b0, 4'd6,  32'hFF,       0},
            '{1'b0, 4'd7,  32'h00,       0},
            '{1'b0, 4'd8,  32'h00,       0},
            '{1'b0, 4'd9,  32'h00,       0},
            '{1'b0, 4'd15, 32'h00,       0},
            '{1'b1, 4'd3,  32'hFF,       0},
            '{1'b0, 4'd3,  32'h00,       0},
            '{1'b1, 4'd2,  32'hFFFFFF00, 0},
            '{1'b0, 4'd2,  32'h00,       0},
            '{1'b1, 4'd6,  32'h0F,       0},
            '{1'b0, 4'd6,  32'h0F,       0},
            '{1'b1, 4'd6,  32'hFF,       0}
        };
        check("irq after reset", 32'(irq), 32'h0);
        run_table(tab1, "reset_tab");

        // Output path: data, outset, outclear compose to 0xCC on all-output pins.
        tb_en = 8'h00;
        tab2 = '{
            '{1'b1, 4'd1, 32'hFF, 0},
            '{1'b0, 4'd1, 32'hFF, 0},
            '{1'b1, 4'd0, 32'hF0, 0},
            '{1'b1, 4'd4, 32'h0C, 0},
            '{1'b1, 4'd5, 32'h30, 0},
            '{1'b0, 4'd4, 32'h00, 0},
            '{1'b0, 4'd5, 32'h00, 0},
            '{1'b0, 4'd0, 32'hCC, LAT + 2}
        };
        run_table(tab2, "out_tab");
        check("pins out", 32'(pins), 32'hCC);

        // Falling-edge capture on pin 0 and W1C release of irq.
        bus_wr(4'd1, 32'h00);
        tb_en  = 8'hFF;
        tb_val = 8'h01;
        repeat (LAT + 4) @(negedge clk);
        bus_wr(4'd3, 32'hFF);
        bus_wr(4'd6, 32'h00);
        bus_wr(4'd7, 32'h01);
        bus_wr(4'd2, 32'h01);
        check("fall irq idle", 32'(irq), 32'h0);
        tb_val = 8'h00;
        repeat (LAT + 2) @(negedge clk);
        check("fall irq early", 32'(irq), 32'h0);
        @(negedge clk);
        check("fall irq set", 32'(irq), 32'h1);
        bus_rd(4'd3, v);
        check("fall capture", v, 32'h01);
        bus_wr(4'd3, 32'h01);
        check("w1c irq lag", 32'(irq), 32'h1);
        @(negedge clk);
        check("w1c irq clear", 32'(irq), 32'h0);
        bus_rd(4'd3, v);
        check("w1c capture", v, 32'h00);

        // Clear colliding with a new rising edge on pin 2: the edge wins.
        bus_wr(4'd6, 32'hFF);
        bus_wr(4'd7, 32'h00);
        bus_wr(4'd3, 32'hFF);
        bus_wr(4'd2, 32'h04);
        tb_val = 8'h04;
        repeat (LAT + 4) @(negedge clk);
        check("rise2 irq", 32'(irq), 32'h1);
        tb_val = 8'h00;
        repeat (LAT + 4) @(negedge clk);
        tb_val = 8'h04;
        repeat (LAT) @(negedge clk);
        bus_wr(4'd3, 32'h04);
        check("collide irq0", 32'(irq), 32'h1);
        @(negedge clk);
        check("collide irq1", 32'(irq), 32'h1);
        bus_rd(4'd3, v);
        check("collide capture", v, 32'h04);

        // Level mode on pin 7: irq follows the filtered level, one cycle ahead of the capture path.
        tb_val = 8'h00;
        repeat (LAT + 4) @(negedge clk);
        bus_wr(4'd3, 32'hFF);
        bus_wr(4'd2, 32'h80);
        bus_wr(4'd8, 32'h80);
        check("level irq idle", 32'(irq), 32'h0);
        tb_val = 8'h80;
        repeat (LAT + 1) @(negedge clk);
        check("level irq early", 32'(irq), 32'h0);
        @(negedge clk);
        check("level irq high", 32'(irq), 32'h1);
        bus_rd(4'd3, v);
        check("level capture", v, 32'h80);
        tb_val = 8'h00;
        repeat (LAT + 2) @(negedge clk);
        check("level irq low", 32'(irq), 32'h0);

`ifdef PIO_DEBOUNCE_EN
        // Debounce: a 10-cycle glitch is rejected, a stable level is accepted, reset kills a count.
        bus_wr(4'd8, 32'h00);
        bus_wr(4'd2, 32'h00);
        bus_wr(4'd3, 32'hFF);
        tb_val = 8'h01;
        repeat (10) @(negedge clk);
        tb_val = 8'h00;
        repeat (30) @(negedge clk);
        bus_rd(4'd3, v);
        check("glitch capture", v, 32'h00);
        tb_val = 8'h01;
        repeat (LAT + 4) @(negedge clk);
        bus_rd(4'd3, v);
        check("stable capture", v, 32'h01);
        tb_val = 8'h00;
        repeat (10) @(negedge clk);
        check("deb count 8", 32'(dut.g_pin[0].u_deb.cnt), 32'd8);
        reset_n = 1'b0;
        tb_en   = 8'hF0;
        #1;
        check("deb reset cnt", 32'(dut.g_pin[0].u_deb.cnt), 32'd0);
        check("deb reset filt", 32'(dut.g_pin[0].u_deb.filt_q), 32'd0);
        check("deb reset readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
